// File: rtl/beagleg_pkg.sv
// Shared command/state definitions for the BeagleG SPI command path.
package beagleg_pkg;

    // Host command opcodes (upper nibble of the command byte)
    typedef enum logic [3:0] {
        CMD_NO_OP        = 4'd0,
        CMD_STATUS       = 4'd1,
        CMD_WRITE_FIFO   = 4'd2,
        CMD_CLEAR_ERRORS = 4'd3
    } command_t;

    // Router decode states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATUS_STREAM,
        ST_WRITE_REC,
        ST_DROP_REC,
        ST_DISCARD
    } router_state_t;

    // Bit positions inside error_flags
    localparam int unsigned ERR_OVERFLOW    = 0;
    localparam int unsigned ERR_BAD_CHANNEL = 1;
    localparam int unsigned ERR_TRUNCATED   = 2;
    localparam int unsigned ERR_CHECKSUM    = 3;
    localparam int unsigned ERR_W           = 4;

    // Clamp a count to what fits in one status byte
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/spi_command_router.sv
// SPI command router: decodes the host byte stream into commands, routes
// motion-segment records to one of CHANNELS FIFOs and streams free-slot status.
// Optional feature macro: ROUTER_CHECKSUM_EN (per-record XOR checksum byte).
module spi_command_router
    import beagleg_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned RECORD_WORDS = 4,
    parameter int unsigned SLOTS        = 16,
    localparam int unsigned SIZE_W      = $clog2(SLOTS * RECORD_WORDS) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spi_cs,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [7:0]                   tx_data,
    input  logic [CHANNELS*SIZE_W-1:0]   fifo_size,
    output logic [CHANNELS-1:0]          fifo_wr_en,
    output logic [7:0]                   fifo_wr_data,
    output logic [ERR_W-1:0]             error_flags
);

    localparam int unsigned LOG2_RW = $clog2(RECORD_WORDS);
    localparam int unsigned IDX_W   = $clog2(RECORD_WORDS + 1);
`ifdef ROUTER_CHECKSUM_EN
    localparam int unsigned LAST_IDX = RECORD_WORDS;
`else
    localparam int unsigned LAST_IDX = RECORD_WORDS - 1;
`endif

    router_state_t        r_state;
    logic [3:0]           r_ch;
    logic [3:0]           r_ptr;
    logic [IDX_W-1:0]     r_idx;
    logic [1:0]           r_guard;
    logic [7:0]           r_tx_data;
    logic [CHANNELS-1:0]  r_wr_en;
    logic [7:0]           r_wr_data;
    logic [ERR_W-1:0]     r_error_flags;
`ifdef ROUTER_CHECKSUM_EN
    logic [7:0]           r_csum;
`endif

    logic [SIZE_W-1:0]    w_free [CHANNELS];
    logic [SIZE_W-1:0]    w_free_min;
    logic [SIZE_W-1:0]    w_free_ch;
    logic [SIZE_W-1:0]    w_free_ptr;
    logic [CHANNELS-1:0]  w_ch_onehot;
    logic                 w_bad_ch;
    logic                 w_rec_overflow;
    logic                 w_last_idx;

    // Per-channel free record slots and write-select decode
    for (genvar c = 0; c < CHANNELS; c++) begin : g_free
        logic [SIZE_W-1:0] w_used;
        assign w_used         = fifo_size[c*SIZE_W +: SIZE_W] >> LOG2_RW;
        assign w_free[c]      = (w_used >= SIZE_W'(SLOTS)) ? '0 : SIZE_W'(SLOTS) - w_used;
        assign w_ch_onehot[c] = (r_ch == 4'(c));
    end

    // Minimum free over all channels plus free() of the selected and streamed channel
    always_comb begin
        w_free_min = w_free[0];
        w_free_ch  = '0;
        w_free_ptr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_free[c] < w_free_min) w_free_min = w_free[c];
            if (r_ch == 4'(c))          w_free_ch  = w_free[c];
            if (r_ptr == 4'(c))         w_free_ptr = w_free[c];
        end
    end

    assign w_bad_ch   = {1'b0, rx_data[3:0]} >= 5'(CHANNELS);
    assign w_last_idx = (r_idx == IDX_W'(LAST_IDX));
    // A record started right after our own record write sees a stale fill level
    assign w_rec_overflow = (r_guard != 2'd0) ? (w_free_ch < SIZE_W'(2)) : (w_free_ch == '0);

    // Command decode FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ch          <= '0;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_guard       <= '0;
            r_tx_data     <= '0;
            r_wr_en       <= '0;
            r_wr_data     <= '0;
            r_error_flags <= '0;
`ifdef ROUTER_CHECKSUM_EN
            r_csum        <= '0;
`endif
        end else begin
            r_wr_en <= '0;
            if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;

            if (spi_cs) begin
                if (r_state == ST_WRITE_REC && r_idx != '0)
                    r_error_flags[ERR_TRUNCATED] <= 1'b1;
                r_state   <= ST_IDLE;
                r_tx_data <= sat8(32'(w_free_min));
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx_data <= sat8(32'(w_free_min));
                        if (rx_valid) begin
                            r_ch  <= rx_data[3:0];
                            r_ptr <= rx_data[3:0];
                            r_idx <= '0;
                            case (command_t'(rx_data[7:4]))
                                CMD_STATUS: begin
                                    if (w_bad_ch) begin
                                        r_error_flags[ERR_BAD_CHANNEL] <= 1'b1;
                                        r_state <= ST_DISCARD;
                                    end else begin
                                        r_tx_data <= {r_error_flags, 4'b0000};
                                        r_state   <= ST_STATUS_STREAM;
                                    end
                                end
                                CMD_WRITE_FIFO: begin
                                    if (w_bad_ch) begin
                                        r_error_flags[ERR_BAD_CHANNEL] <= 1'b1;
                                        r_state <= ST_DISCARD;
                                    end else begin
                                        r_state <= ST_WRITE_REC;
                                    end
                                end
                                CMD_CLEAR_ERRORS: r_error_flags <= '0;
                                default: ;
                            endcase
                        end
                    end
                    ST_STATUS_STREAM: begin
                        if (rx_valid) begin
                            r_tx_data <= sat8(32'(w_free_ptr));
                            r_ptr     <= (r_ptr == 4'(CHANNELS - 1)) ? 4'd0 : r_ptr + 4'd1;
                        end
                    end
                    ST_WRITE_REC: begin
                        if (rx_valid) begin
                            if (r_idx == '0 && w_rec_overflow) begin
                                r_error_flags[ERR_OVERFLOW] <= 1'b1;
                                r_idx   <= IDX_W'(1);
                                r_state <= ST_DROP_REC;
                            end
`ifdef ROUTER_CHECKSUM_EN
                            else if (r_idx == IDX_W'(RECORD_WORDS)) begin
                                if (r_csum != rx_data) r_error_flags[ERR_CHECKSUM] <= 1'b1;
                                r_idx <= '0;
                            end
`endif
                            else begin
                                r_wr_en   <= w_ch_onehot;
                                r_wr_data <= rx_data;
`ifdef ROUTER_CHECKSUM_EN
                                r_csum    <= (r_idx == '0) ? rx_data : (r_csum ^ rx_data);
`endif
                                if (r_idx == IDX_W'(RECORD_WORDS - 1)) r_guard <= 2'd2;
                                r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_DROP_REC: begin
                        if (rx_valid) begin
                            r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
                            if (w_last_idx) r_state <= ST_WRITE_REC;
                        end
                    end
                    ST_DISCARD: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx_data      = r_tx_data;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign error_flags  = r_error_flags;

endmodule

// File: tb/tb_spi_command_router.sv
// Directed self-checking bench for spi_command_router (CHANNELS=2, RECORD_WORDS=4, SLOTS=16).
module tb_spi_command_router;

    localparam int unsigned CH     = 2;
    localparam int unsigned SIZE_W = 7;

    logic                 clk;
    logic                 reset;
    logic                 spi_cs;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic [CH*SIZE_W-1:0] fifo_size;
    logic [CH-1:0]        fifo_wr_en;
    logic [7:0]           fifo_wr_data;
    logic [3:0]           error_flags;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] log_en[$];
    logic [7:0] log_data[$];
    logic [7:0] burst[$];

    spi_command_router dut (
        .clk          (clk),
        .reset        (reset),
        .spi_cs       (spi_cs),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .fifo_size    (fifo_size),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .error_flags  (error_flags)
    );

    always #5 clk = ~clk;

    // Record every FIFO write strobe away from the active edge
    always @(negedge clk) begin
        if (fifo_wr_en != '0) begin
            log_en.push_back(fifo_wr_en);
            log_data.push_back(fifo_wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        idle(3);
    endtask

    // Four data bytes, followed by their XOR when the checksum build is active
    task automatic send_rec(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
`ifdef ROUTER_CHECKSUM_EN
        send_byte(b0 ^ b1 ^ b2 ^ b3);
`endif
    endtask

    // Back-to-back bytes, one per clock
    task automatic send_burst();
        foreach (burst[i]) begin
            @(negedge clk);
            rx_data  = burst[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        idle(3);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs = 1'b0;
        idle(2);
    endtask

    task automatic cs_high();
        @(negedge clk);
        spi_cs = 1'b1;
        idle(2);
    endtask

    task automatic clear_log();
        log_en.delete();
        log_data.delete();
    endtask

    // Compare the write log against n expected writes of one strobe pattern
    task automatic check_writes(input string tag, input int n, input logic [1:0] en,
                                input logic [31:0] data);
        logic [31:0] d;
        d = data;
        check({tag, "_count"}, 32'(log_en.size()), 32'(n));
        for (int i = 0; i < n && i < log_en.size(); i++) begin
            check({tag, "_en"}, 32'(log_en[i]), 32'(en));
            check({tag, "_data"}, 32'(log_data[i]), 32'(d[7:0]));
            d = d >> 8;
        end
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        spi_cs    = 1'b1;
        rx_data   = '0;
        rx_valid  = 1'b0;
        fifo_size = '0;
        idle(3);

        // Reset values
        check("rst_tx", 32'(tx_data), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_flags", 32'(error_flags), 32'h0);
        reset = 1'b0;
        idle(2);
        check("idle_tx_min_free", 32'(tx_data), 32'd16);

        // Reset during a record (next byte would be index 2)
        cs_low();
        send_byte(8'h21);
        send_byte(8'hA0);
        send_byte(8'hA1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("midrst_wr_data", 32'(fifo_wr_data), 32'h0);
        check("midrst_tx", 32'(tx_data), 32'h0);
        check("midrst_flags", 32'(error_flags), 32'h0);
        idle(1);
        reset = 1'b0;
        clear_log();
        send_byte(8'hA2);
        check_writes("midrst_nowrite", 0, 2'b00, 32'h0);
        cs_high();

        // Record into channel 1
        clear_log();
        cs_low();
        send_byte(8'h21);
        send_rec(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        cs_high();
        check_writes("wr_ch1", 4, 2'b10, 32'hA3A2A1A0);
        check("wr_ch1_flags", 32'(error_flags), 32'h0);

        // Channel 0 full: record dropped, overflow set
        fifo_size = {7'd0, 7'd64};
        clear_log();
        cs_low();
        send_byte(8'h20);
        send_rec(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        cs_high();
        check_writes("full_ch0", 0, 2'b00, 32'h0);
        check("full_flags", 32'(error_flags), 32'h1);
        check("full_tx_min", 32'(tx_data), 32'h0);

        // Status stream from channel 0, including pointer wrap
        cs_low();
        send_byte(8'h10);
        check("status_flags_byte", 32'(tx_data), 32'h10);
        send_byte(8'h00);
        check("status_free0", 32'(tx_data), 32'd0);
        send_byte(8'h00);
        check("status_free1", 32'(tx_data), 32'd16);
        send_byte(8'h00);
        check("status_wrap_free0", 32'(tx_data), 32'd0);
        cs_high();

        // Bad channel: everything discarded until cs rises
        fifo_size = '0;
        clear_log();
        cs_low();
        send_byte(8'h25);
        for (int i = 0; i < 8; i++) send_byte(8'h21);
        cs_high();
        check_writes("badch", 0, 2'b00, 32'h0);
        check("badch_flags", 32'(error_flags), 32'h3);

        // Clear errors
        cs_low();
        send_byte(8'h30);
        check("clear_flags", 32'(error_flags), 32'h0);
        cs_high();

        // Truncated record: written bytes stay, flag set, back in IDLE
        clear_log();
        cs_low();
        send_byte(8'h20);
        send_byte(8'h11);
        send_byte(8'h22);
        cs_high();
        check_writes("trunc", 2, 2'b01, 32'h00002211);
        check("trunc_flags", 32'(error_flags), 32'h4);
        check("trunc_idle_tx", 32'(tx_data), 32'd16);
        cs_low();
        send_byte(8'h30);
        cs_high();
        check("trunc_cleared", 32'(error_flags), 32'h0);

        // Byte coincident with cs rising is ignored
        clear_log();
        cs_low();
        send_byte(8'h20);
        @(negedge clk);
        spi_cs   = 1'b1;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        idle(3);
        check_writes("cs_wins", 0, 2'b00, 32'h0);
        check("cs_wins_flags", 32'(error_flags), 32'h0);

        // One free slot, back-to-back records: second record hits the in-flight guard
        fifo_size = {7'd60, 7'd0};
        clear_log();
        cs_low();
        send_byte(8'h21);
        burst.delete();
        burst.push_back(8'hC0); burst.push_back(8'hC1);
        burst.push_back(8'hC2); burst.push_back(8'hC3);
`ifdef ROUTER_CHECKSUM_EN
        burst.push_back(8'hC0 ^ 8'hC1 ^ 8'hC2 ^ 8'hC3);
`endif
        burst.push_back(8'hD0); burst.push_back(8'hD1);
        burst.push_back(8'hD2); burst.push_back(8'hD3);
`ifdef ROUTER_CHECKSUM_EN
        burst.push_back(8'hD0 ^ 8'hD1 ^ 8'hD2 ^ 8'hD3);
`endif
        send_burst();
        cs_high();
        check_writes("guard", 4, 2'b10, 32'hC3C2C1C0);
        check("guard_flags", 32'(error_flags), 32'h1);
        fifo_size = '0;
        cs_low();
        send_byte(8'h30);
        cs_high();

`ifdef ROUTER_CHECKSUM_EN
        // Good checksum
        clear_log();
        cs_low();
        send_byte(8'h20);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0F);
        cs_high();
        check_writes("ck_good", 4, 2'b01, 32'h08040201);
        check("ck_good_flags", 32'(error_flags), 32'h0);

        // Bad checksum: record still committed, flag set
        clear_log();
        cs_low();
        send_byte(8'h20);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h00);
        cs_high();
        check_writes("ck_bad", 4, 2'b01, 32'h08040201);
        check("ck_bad_flags", 32'(error_flags), 32'h8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
